// File: rtl/sp_isa_pkg.sv
// sp_isa_pkg: shared definitions for the instruction sequencer.
//   Widths, instruction field positions, opcodes, one-hot index constants,
//   ALU operation codes, FSM state encoding and a one-hot helper function.
package sp_isa_pkg;

  localparam int DATA_W   = 16;
  localparam int INSTR_W  = 23;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 8;
  localparam int OH_W     = NUM_REGS + 2;

  // Instruction field positions
  localparam int OP_HI   = 22;
  localparam int OP_LO   = 19;
  localparam int RX_HI   = 18;
  localparam int RX_LO   = 16;
  localparam int RY_HI   = 15;
  localparam int RY_LO   = 13;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int ADDR_HI = 5;
  localparam int ADDR_LO = 0;

  // Opcodes; 10..15 are undefined
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MV   = 4'd1;
  localparam logic [3:0] OP_MVI  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_BZ   = 4'd6;
  localparam logic [3:0] OP_BNZ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  // Load-enable indices above the general registers
  localparam logic [3:0] IDX_A   = 4'd8;
  localparam logic [3:0] IDX_G   = 4'd9;
  // Bus-source indices above the general registers
  localparam logic [3:0] SRC_G   = 4'd8;
  localparam logic [3:0] SRC_IMM = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EX1    = 3'd2,
    ST_EX2    = 3'd3,
    ST_EX3    = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  // One-hot vector with only bit idx set (idx < OH_W)
  function automatic logic [OH_W-1:0] onehot(input logic [3:0] idx);
    onehot = {{(OH_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/sp_instr_decode.sv
// sp_instr_decode: combinational micro-step decode.
//   state_i     current sequencer state
//   inst_reg_i  latched instruction
//   bus_zero_i  datapath bus is zero (used only by conditional branches)
//   r_en_oh_o   register load enable, one-hot or zero
//   tri_oh_o    bus driver select, one-hot or zero
//   alu_op_o    ALU operation, non-zero only in EX2
//   imm_o       immediate, zero unless the immediate drives the bus
//   branch_o    PC load request
//   illegal_o   undefined opcode seen in EX1
module sp_instr_decode
  import sp_isa_pkg::*;
(
  input  state_e              state_i,
  input  logic [INSTR_W-1:0]  inst_reg_i,
  input  logic                bus_zero_i,
  output logic [OH_W-1:0]     r_en_oh_o,
  output logic [OH_W-1:0]     tri_oh_o,
  output logic [1:0]          alu_op_o,
  output logic [DATA_W-1:0]   imm_o,
  output logic                branch_o,
  output logic                illegal_o
);

  logic [3:0] op_s;
  logic [3:0] rx_s;
  logic [3:0] ry_s;

  assign op_s = inst_reg_i[OP_HI:OP_LO];
  assign rx_s = {1'b0, inst_reg_i[RX_HI:RX_LO]};
  assign ry_s = {1'b0, inst_reg_i[RY_HI:RY_LO]};

  // Per-state, per-opcode bus source / load / control decode
  always_comb begin
    r_en_oh_o = '0;
    tri_oh_o  = '0;
    alu_op_o  = ALU_ADD;
    imm_o     = '0;
    branch_o  = 1'b0;
    illegal_o = 1'b0;
    case (state_i)
      ST_EX1: begin
        case (op_s)
          OP_NOP, OP_HALT: begin
          end
          OP_MV: begin
            tri_oh_o  = onehot(ry_s);
            r_en_oh_o = onehot(rx_s);
          end
          OP_MVI: begin
            tri_oh_o  = onehot(SRC_IMM);
            r_en_oh_o = onehot(rx_s);
            imm_o     = inst_reg_i[IMM_HI:IMM_LO];
          end
          OP_ADD, OP_SUB, OP_AND: begin
            tri_oh_o  = onehot(rx_s);
            r_en_oh_o = onehot(IDX_A);
          end
          OP_BZ: begin
            tri_oh_o = onehot(rx_s);
            branch_o = bus_zero_i;
          end
          OP_BNZ: begin
            tri_oh_o = onehot(rx_s);
            branch_o = ~bus_zero_i;
          end
          OP_JMP: begin
            branch_o = 1'b1;
          end
          default: begin
            illegal_o = 1'b1;
          end
        endcase
      end
      ST_EX2: begin
        tri_oh_o  = onehot(ry_s);
        r_en_oh_o = onehot(IDX_G);
        case (op_s)
          OP_SUB:  alu_op_o = ALU_SUB;
          OP_AND:  alu_op_o = ALU_AND;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      ST_EX3: begin
        tri_oh_o  = onehot(SRC_G);
        r_en_oh_o = onehot(rx_s);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the shared-bus datapath.
//   clk, rst            clock and synchronous active-high reset
//   start               leave IDLE/HALTED and begin fetching
//   instr_valid/ready   instruction fetch handshake (ready only in FETCH)
//   instr               instruction word
//   bus_zero            datapath bus is zero, same cycle
//   r_en_OH             register load one-hot: R0..R7, A, G
//   tri_controller_OH   bus driver one-hot: R0..R7, G, immediate
//   alu_op, imm_out     ALU operation and immediate value
//   inc_pc, branch      PC controls; branch_addr is the target address
//   inst_reg            latched instruction
//   busy, done, illegal status
module instr_sequencer
  import sp_isa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                bus_zero,
  output logic [OH_W-1:0]     r_en_OH,
  output logic [OH_W-1:0]     tri_controller_OH,
  output logic [1:0]          alu_op,
  output logic [DATA_W-1:0]   imm_out,
  output logic                inc_pc,
  output logic                branch,
  output logic [ADDR_W-1:0]   branch_addr,
  output logic [INSTR_W-1:0]  inst_reg,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   inst_reg_q, inst_reg_d;
  logic [3:0]           op_s;

  assign op_s = inst_reg_q[OP_HI:OP_LO];

  // Next-state, instruction latch and fetch handshake outputs
  always_comb begin
    state_d     = state_q;
    inst_reg_d  = inst_reg_q;
    instr_ready = 1'b0;
    inc_pc      = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        instr_ready = 1'b1;
        // A handshake in a reset cycle is discarded, so it must not step the PC
        if (instr_valid && !rst) begin
          inst_reg_d = instr;
          inc_pc     = 1'b1;
          state_d    = ST_EX1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EX1: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND: state_d = ST_EX2;
          OP_HALT:                state_d = ST_HALTED;
          default:                state_d = ST_FETCH;
        endcase
      end
      ST_EX2:  state_d = ST_EX3;
      ST_EX3:  state_d = ST_FETCH;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and instruction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inst_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      inst_reg_q <= inst_reg_d;
    end
  end

  sp_instr_decode u_decode (
    .state_i    (state_q),
    .inst_reg_i (inst_reg_q),
    .bus_zero_i (bus_zero),
    .r_en_oh_o  (r_en_OH),
    .tri_oh_o   (tri_controller_OH),
    .alu_op_o   (alu_op),
    .imm_o      (imm_out),
    .branch_o   (branch),
    .illegal_o  (illegal)
  );

  assign inst_reg    = inst_reg_q;
  assign branch_addr = inst_reg_q[ADDR_HI:ADDR_LO];
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign done        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver pushes the expected
// per-cycle micro-steps of every accepted instruction; a monitor pops and
// compares them on each execute cycle and checks quiet outputs otherwise.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, instr_valid, bus_zero;
  logic [22:0] instr;
  logic        instr_ready, inc_pc, branch, busy, done, illegal;
  logic [9:0]  r_en_OH, tri_controller_OH;
  logic [1:0]  alu_op;
  logic [15:0] imm_out;
  logic [5:0]  branch_addr;
  logic [22:0] inst_reg;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr             (instr),
    .bus_zero          (bus_zero),
    .r_en_OH           (r_en_OH),
    .tri_controller_OH (tri_controller_OH),
    .alu_op            (alu_op),
    .imm_out           (imm_out),
    .inc_pc            (inc_pc),
    .branch            (branch),
    .branch_addr       (branch_addr),
    .inst_reg          (inst_reg),
    .busy              (busy),
    .done              (done),
    .illegal           (illegal)
  );

  typedef struct packed {
    logic [9:0]  ren;
    logic [9:0]  src;
    logic [1:0]  alu;
    logic [15:0] imm;
    logic        br;
    logic        ill;
    logic [5:0]  baddr;
    logic [22:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: expected micro-steps of one instruction, pushed in
  // execution order. Returns handshake-to-ready latency (0 for HALT).
  function automatic int model(input logic [22:0] w, input logic bz);
    int   op = int'(w[22:19]);
    int   rx = int'(w[18:16]);
    int   ry = int'(w[15:13]);
    exp_t e;
    e = '0;
    e.baddr = w[5:0];
    e.word  = w;
    if (op == 1) begin
      e.src = 10'(1 << ry); e.ren = 10'(1 << rx);
    end else if (op == 2) begin
      e.src = 10'(1 << 9); e.ren = 10'(1 << rx); e.imm = w[15:0];
    end else if (op >= 3 && op <= 5) begin
      e.src = 10'(1 << rx); e.ren = 10'(1 << 8);
      exp_q.push_back(e);
      e.src = 10'(1 << ry); e.ren = 10'(1 << 9); e.alu = 2'(op - 3);
      exp_q.push_back(e);
      e.src = 10'(1 << 8); e.ren = 10'(1 << rx); e.alu = 2'b00;
      exp_q.push_back(e);
      return 4;
    end else if (op == 6) begin
      e.src = 10'(1 << rx); e.br = bz;
    end else if (op == 7) begin
      e.src = 10'(1 << rx); e.br = ~bz;
    end else if (op == 8) begin
      e.br = 1'b1;
    end else if (op >= 10) begin
      e.ill = 1'b1;
    end
    exp_q.push_back(e);
    return (op == 9) ? 0 : 2;
  endfunction

  // Monitor: compare execute cycles against the scoreboard, idle cycles against zero
  always @(negedge clk) begin
    if (started) begin
      chk("onehot_r_en", 32'($onehot0(r_en_OH)), 32'd1);
      chk("onehot_tri", 32'($onehot0(tri_controller_OH)), 32'd1);
      chk("inc_pc_and_branch", 32'(inc_pc & branch), 32'd0);
      if (!instr_valid) chk("inc_pc_without_valid", 32'(inc_pc), 32'd0);
      if (busy && !instr_ready && !done) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("r_en_OH", 32'(r_en_OH), 32'(e.ren));
          chk("tri_controller_OH", 32'(tri_controller_OH), 32'(e.src));
          chk("alu_op", 32'(alu_op), 32'(e.alu));
          chk("imm_out", 32'(imm_out), 32'(e.imm));
          chk("branch", 32'(branch), 32'(e.br));
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("branch_addr", 32'(branch_addr), 32'(e.baddr));
          chk("inst_reg", 32'(inst_reg), 32'(e.word));
        end
      end else begin
        chk("idle_r_en", 32'(r_en_OH), 32'd0);
        chk("idle_tri", 32'(tri_controller_OH), 32'd0);
        chk("idle_ctrl", 32'({alu_op, branch, illegal}), 32'd0);
        chk("idle_imm", 32'(imm_out), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one instruction from FETCH and follow it back to FETCH
  task automatic run_instr(input logic [22:0] w, input logic bz);
    int lat;
    int cyc;
    instr       = w;
    instr_valid = 1'b1;
    bus_zero    = bz;
    lat         = model(w, bz);
    #1;
    chk("inc_pc_handshake", 32'(inc_pc), 32'd1);
    tick();
    instr_valid = 1'b0;
    instr       = 23'($urandom);
    start       = 1'($urandom_range(0, 1));
    cyc         = 1;
    while (!(instr_ready || done) && cyc < 20) begin
      tick();
      cyc++;
      if (!(instr_ready || done)) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
    end
    start = 1'b0;
    if (lat == 0) begin
      chk("halt_latency", 32'(cyc), 32'd2);
      for (int i = 0; i < 5; i++) begin
        chk("halt_done", 32'({done, instr_ready, busy}), 32'b100);
        tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("halt_restart", 32'({done, instr_ready}), 32'b01);
    end else begin
      chk("latency", 32'(cyc), 32'(lat));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; bus_zero = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", 32'({instr_ready, inc_pc, branch, busy, done, illegal}), 32'd0);
    chk("reset_vectors", 32'({r_en_OH, tri_controller_OH, alu_op}), 32'd0);
    chk("reset_inst_reg", 32'(inst_reg), 32'd0);
    rst = 1'b0;
    started = 1'b1;
    tick();
    chk("idle_without_start", 32'({busy, instr_ready}), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_entry", 32'({instr_ready, inc_pc, busy}), 32'b101);
    tick();
    chk("fetch_waits", 32'({instr_ready, inc_pc}), 32'b10);

    run_instr({4'd2, 3'd3, 16'h00A5}, 1'b0);          // MVI R3,0x00A5
    run_instr({4'd4, 3'd1, 3'd2, 13'd0}, 1'b0);       // SUB R1,R2
    run_instr({4'd6, 3'd4, 10'd0, 6'd17}, 1'b1);      // BZ taken
    run_instr({4'd6, 3'd4, 10'd0, 6'd17}, 1'b0);      // BZ not taken
    run_instr({4'd7, 3'd4, 10'd0, 6'd17}, 1'b0);      // BNZ taken
    run_instr({4'd7, 3'd4, 10'd0, 6'd17}, 1'b1);      // BNZ not taken
    run_instr({4'd8, 13'd0, 6'd63}, 1'b0);            // JMP
    run_instr({4'd3, 3'd5, 3'd5, 13'd0}, 1'b0);       // ADD R5,R5
    run_instr({4'hF, 19'h5A5A5}, 1'b0);               // illegal
    run_instr({4'd9, 19'd0}, 1'b0);                   // HALT

    // Reset during EX2 of ADD R5,R6
    instr = {4'd3, 3'd5, 3'd6, 13'd0};
    instr_valid = 1'b1;
    void'(model(instr, 1'b0));
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_alu_reset_state", 32'({busy, instr_ready, done}), 32'd0);
    chk("mid_alu_reset_r_en", 32'(r_en_OH), 32'd0);
    chk("mid_alu_reset_inst_reg", 32'(inst_reg), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_fetch", 32'(instr_ready), 32'd1);

    for (int n = 0; n < 150; n++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      run_instr(23'($urandom), 1'($urandom_range(0, 1)));
    end

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
